aurora_os_detector: RTL and testbench

- Per-lane receive-side ordered-set detector.
- Sits between the lane's 8b/10b decoder (8-bit symbol, K flag, code-error flag) and the lane-init/channel-init logic.
- Recognises single- and multi-symbol Aurora ordered sets and reports each as one `ordered_sets_e` result with valid and error flags.
- One instance per lane, up to MAX_LINKS instances.

---
 rtl/aurora_pkg.sv | 36 +++
 rtl/aurora_os_detector.sv | 198 +++++++++++++++++++
 tb/tb_aurora_os_detector.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aurora_pkg.sv
// Shared Aurora receive-side definitions: ordered-set result codes, 8b/10b
// symbol codes and the ordered-set detector state encoding.
package aurora_pkg;

  localparam int INTERMEDIATE_DATA_SIZE = 8;
  localparam int ORDERED_SETS_SIZE      = 4;
  localparam int MAX_LINKS              = 4;

  typedef enum logic [ORDERED_SETS_SIZE-1:0] {
    NONE, K, R, A, I, SP, SPA, VER, SCP, ECP, CC, SNF, SUF, P
  } ordered_sets_e;

  // K-characters
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_6 = 8'hDC;

  // D-characters used inside ordered sets
  localparam logic [7:0] D21_4 = 8'h95;
  localparam logic [7:0] D10_2 = 8'h4A;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D12_2 = 8'h4C;

  typedef enum logic [3:0] {
    IDLE, HDR, SP1, SP2, SPA1, SPA2, VER1, VER2, SCP1, ECP1, CC1, SUF1
  } os_det_state_e;

endpackage

// File: rtl/aurora_os_detector.sv
// Per-lane ordered-set detector: turns decoded 8b/10b symbols into one
// registered ordered_sets_e result per cycle, with a one-entry lookahead slot.
module aurora_os_detector
  import aurora_pkg::*;
#(
  parameter int IDLE_RUN = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [INTERMEDIATE_DATA_SIZE-1:0] rx_data,
  input  logic                              rx_is_k,
  input  logic                              rx_err,
  input  logic                              rx_valid,
  output logic                              rx_ready,
  output logic                              os_valid,
  output ordered_sets_e                     os_type,
  output logic                              os_err
);

  localparam logic [3:0] RUN_LEN = 4'(IDLE_RUN);

  os_det_state_e state_reg, state_next;
  logic          pend_valid_reg, pend_valid_next;
  ordered_sets_e pend_type_reg, pend_type_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic          os_valid_reg, os_valid_next;
  ordered_sets_e os_type_reg, os_type_next;
  logic          os_err_reg, os_err_next;

  logic          accept;
  os_det_state_e idle_state;
  logic          idle_v;
  ordered_sets_e idle_t;
  logic          idle_d;

  assign rx_ready = !pend_valid_reg;
  assign accept   = rx_valid && rx_ready;
  assign os_valid = os_valid_reg;
  assign os_type  = os_type_reg;
  assign os_err   = os_err_reg;

  function automatic logic hit(input logic [7:0] code, input logic code_k);
    return (rx_data == code) && (rx_is_k == code_k);
  endfunction

  // What the current symbol would do if the FSM were in IDLE; reused for
  // reprocessing after a mismatch or a bare K28.5.
  always_comb begin
    idle_state = IDLE;
    idle_v     = 1'b0;
    idle_t     = NONE;
    idle_d     = !rx_is_k;
    if (rx_is_k) begin
      case (rx_data)
        K28_5:   idle_state = HDR;
        K28_2:   idle_state = SCP1;
        K29_7:   idle_state = ECP1;
        K23_7:   idle_state = CC1;
        K28_6:   idle_state = SUF1;
        K28_0:   begin idle_v = 1'b1; idle_t = R; end
        K28_3:   begin idle_v = 1'b1; idle_t = A; end
        K28_4:   begin idle_v = 1'b1; idle_t = P; end
        default: begin idle_v = 1'b1; idle_t = NONE; end
      endcase
    end
  end

  always_comb begin
    logic          prim_v;
    ordered_sets_e prim_t;
    logic          reproc;
    logic          match;
    logic          fin;
    os_det_state_e adv;
    ordered_sets_e done;
    logic          clr;

    state_next      = state_reg;
    pend_valid_next = pend_valid_reg;
    pend_type_next  = pend_type_reg;
    cnt_next        = cnt_reg;
    os_valid_next   = 1'b0;
    os_type_next    = NONE;
    os_err_next     = 1'b0;
    prim_v = 1'b0;
    prim_t = NONE;
    reproc = 1'b0;
    match  = 1'b0;
    fin    = 1'b0;
    adv    = IDLE;
    done   = NONE;
    clr    = 1'b0;

    case (state_reg)
      SP1:  begin match = hit(D10_2, 1'b0); adv = SP2; end
      SP2:  begin match = hit(D10_2, 1'b0); fin = 1'b1; done = SP; end
      SPA1: begin match = hit(D12_2, 1'b0); adv = SPA2; end
      SPA2: begin match = hit(D12_2, 1'b0); fin = 1'b1; done = SPA; end
      VER1: begin match = hit(K28_1, 1'b1); adv = VER2; end
      VER2: begin match = hit(K28_1, 1'b1); fin = 1'b1; done = VER; end
      SCP1: begin match = hit(K27_7, 1'b1); fin = 1'b1; done = SCP; end
      ECP1: begin match = hit(K30_7, 1'b1); fin = 1'b1; done = ECP; end
      CC1:  begin match = hit(K23_7, 1'b1); fin = 1'b1; done = CC; end
      SUF1: begin
        fin = 1'b1;
        if (hit(K28_6, 1'b1)) begin match = 1'b1; done = SNF; end
        else if (hit(K28_4, 1'b1)) begin match = 1'b1; done = SUF; end
      end
      default: ;
    endcase

    if (pend_valid_reg) begin
      prim_v          = 1'b1;
      prim_t          = pend_type_reg;
      pend_valid_next = 1'b0;
    end else if (accept) begin
      if (rx_err) begin
        prim_v     = 1'b1;
        prim_t     = NONE;
        state_next = IDLE;
      end else if (state_reg == IDLE) begin
        state_next = idle_state;
        prim_v     = idle_v;
        prim_t     = idle_t;
        clr        = idle_d;
      end else if (state_reg == HDR) begin
        if (hit(D21_4, 1'b0))      state_next = SP1;
        else if (hit(D21_5, 1'b0)) state_next = SPA1;
        else if (hit(K28_1, 1'b1)) state_next = VER1;
        else begin
          prim_v = 1'b1;
          prim_t = K;
          reproc = 1'b1;
        end
      end else if (match) begin
        if (fin) begin
          prim_v     = 1'b1;
          prim_t     = done;
          state_next = IDLE;
        end else begin
          state_next = adv;
        end
      end else begin
        prim_v = 1'b1;
        prim_t = NONE;
        reproc = 1'b1;
      end
    end

    if (reproc) begin
      state_next = idle_state;
      clr        = idle_d;
      if (idle_v) begin
        pend_valid_next = 1'b1;
        pend_type_next  = idle_t;
      end
    end

    // Idle-class results feed the run counter; the run-completing one becomes I.
    if (prim_v) begin
      os_valid_next = 1'b1;
      os_type_next  = prim_t;
      os_err_next   = (prim_t == NONE);
      if (prim_t == K || prim_t == R || prim_t == A) begin
        if (cnt_reg + 4'd1 == RUN_LEN) begin
          os_type_next = I;
          cnt_next     = 4'd0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end else begin
        cnt_next = 4'd0;
      end
    end
    if (clr) cnt_next = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pend_valid_reg <= 1'b0;
      pend_type_reg  <= NONE;
      cnt_reg        <= 4'd0;
      os_valid_reg   <= 1'b0;
      os_type_reg    <= NONE;
      os_err_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pend_valid_reg <= pend_valid_next;
      pend_type_reg  <= pend_type_next;
      cnt_reg        <= cnt_next;
      os_valid_reg   <= os_valid_next;
      os_type_reg    <= os_type_next;
      os_err_reg     <= os_err_next;
    end
  end

endmodule

// File: tb/tb_aurora_os_detector.sv
// Directed bench for aurora_os_detector: one task per scenario, inline
// comparisons against hand-derived results.
module tb_aurora_os_detector;
  import aurora_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_is_k;
  logic          rx_err;
  logic          rx_valid;
  logic          rx_ready;
  logic          os_valid;
  ordered_sets_e os_type;
  logic          os_err;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  aurora_os_detector #(.IDLE_RUN(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_is_k  (rx_is_k),
    .rx_err   (rx_err),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .os_valid (os_valid),
    .os_type  (os_type),
    .os_err   (os_err)
  );

  task automatic drive(input logic [7:0] d, input logic k, input logic e);
    rx_data  = d;
    rx_is_k  = k;
    rx_err   = e;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic gap();
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (os_valid !== 1'b0 || os_type !== NONE || os_err !== 1'b0 || rx_ready !== 1'b1)
      $display("FAIL reset_state: got v=%0b t=%0d e=%0b rdy=%0b, want v=0 t=0 e=0 rdy=1",
               os_valid, os_type, os_err, rx_ready);
    else passes++;
    $display("reset: v=%0b t=%0d e=%0b rdy=%0b", os_valid, os_type, os_err, rx_ready);
  endtask

  task automatic test_sp();
    logic [7:0] seq [4];
    logic       kk  [4];
    seq = '{8'hBC, 8'h95, 8'h4A, 8'h4A};
    kk  = '{1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int n = 0; n < 4; n++) begin
      drive(seq[n], kk[n], 1'b0);
      checks++;
      if (rx_ready !== 1'b1 || os_valid !== (n == 3) || (n == 3 && (os_type !== SP || os_err !== 1'b0)))
        $display("FAIL sp_sym%0d: got v=%0b t=%0d e=%0b rdy=%0b, want v=%0b t=%0d e=0 rdy=1",
                 n, os_valid, os_type, os_err, rx_ready, n == 3, SP);
      else passes++;
      $display("sp: sym=%02h v=%0b t=%0d e=%0b", seq[n], os_valid, os_type, os_err);
    end
    gap();
    checks++;
    if (os_valid !== 1'b0) $display("FAIL sp_single: got v=%0b, want v=0", os_valid);
    else passes++;
  endtask

  task automatic test_lookahead();
    do_reset();
    drive(8'hBC, 1'b1, 1'b0);
    drive(8'h1C, 1'b1, 1'b0);
    checks++;
    if (os_valid !== 1'b1 || os_type !== K || os_err !== 1'b0 || rx_ready !== 1'b0)
      $display("FAIL look_k: got v=%0b t=%0d e=%0b rdy=%0b, want v=1 t=%0d e=0 rdy=0",
               os_valid, os_type, os_err, rx_ready, K);
    else passes++;
    $display("lookahead: n+1 v=%0b t=%0d rdy=%0b", os_valid, os_type, rx_ready);
    gap();
    checks++;
    if (os_valid !== 1'b1 || os_type !== R || rx_ready !== 1'b1)
      $display("FAIL look_r: got v=%0b t=%0d rdy=%0b, want v=1 t=%0d rdy=1",
               os_valid, os_type, rx_ready, R);
    else passes++;
    $display("lookahead: n+2 v=%0b t=%0d rdy=%0b", os_valid, os_type, rx_ready);
  endtask

  task automatic test_idle_run();
    logic [7:0]    seq [9];
    ordered_sets_e exp [9];
    logic          ev  [9];
    seq = '{8'h1C, 8'h7C, 8'h1C, 8'h1C, 8'h7C, 8'h00, 8'h1C, 8'h1C, 8'h1C};
    exp = '{R, A, R, I, A, NONE, R, R, R};
    ev  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int n = 0; n < 9; n++) begin
      drive(seq[n], n != 5, 1'b0);
      checks++;
      if (os_valid !== ev[n] || (ev[n] && (os_type !== exp[n] || os_err !== 1'b0)))
        $display("FAIL idle_run%0d: got v=%0b t=%0d e=%0b, want v=%0b t=%0d e=0",
                 n, os_valid, os_type, os_err, ev[n], exp[n]);
      else passes++;
      $display("idle_run: sym=%02h v=%0b t=%0d", seq[n], os_valid, os_type);
    end
  endtask

  task automatic test_malformed();
    do_reset();
    drive(8'hBC, 1'b1, 1'b0);
    drive(8'h95, 1'b0, 1'b0);
    drive(8'h4A, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    checks++;
    if (os_valid !== 1'b1 || os_type !== NONE || os_err !== 1'b1)
      $display("FAIL malformed: got v=%0b t=%0d e=%0b, want v=1 t=0 e=1", os_valid, os_type, os_err);
    else passes++;
    $display("malformed: v=%0b t=%0d e=%0b", os_valid, os_type, os_err);
    drive(8'h5C, 1'b1, 1'b0);
    drive(8'hFB, 1'b1, 1'b0);
    checks++;
    if (os_valid !== 1'b1 || os_type !== SCP || os_err !== 1'b0)
      $display("FAIL scp_after: got v=%0b t=%0d e=%0b, want v=1 t=%0d e=0", os_valid, os_type, os_err, SCP);
    else passes++;
    $display("scp: v=%0b t=%0d e=%0b", os_valid, os_type, os_err);
  endtask

  task automatic test_abort();
    do_reset();
    drive(8'hBC, 1'b1, 1'b0);
    drive(8'h3C, 1'b1, 1'b0);
    drive(8'h3C, 1'b1, 1'b1);
    checks++;
    if (os_valid !== 1'b1 || os_type !== NONE || os_err !== 1'b1 || rx_ready !== 1'b1)
      $display("FAIL abort_err: got v=%0b t=%0d e=%0b rdy=%0b, want v=1 t=0 e=1 rdy=1",
               os_valid, os_type, os_err, rx_ready);
    else passes++;
    $display("abort: v=%0b t=%0d e=%0b", os_valid, os_type, os_err);
    drive(8'h3C, 1'b1, 1'b0);
    checks++;
    if (os_valid !== 1'b1 || os_type !== NONE || os_err !== 1'b1)
      $display("FAIL stray_k: got v=%0b t=%0d e=%0b, want v=1 t=0 e=1", os_valid, os_type, os_err);
    else passes++;
    $display("stray_k: v=%0b t=%0d e=%0b", os_valid, os_type, os_err);
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(8'hBC, 1'b1, 1'b0);
    drive(8'h95, 1'b0, 1'b0);
    do_reset();
    checks++;
    if (os_valid !== 1'b0 || os_type !== NONE || os_err !== 1'b0 || rx_ready !== 1'b1)
      $display("FAIL reset_mid: got v=%0b t=%0d e=%0b rdy=%0b, want v=0 t=0 e=0 rdy=1",
               os_valid, os_type, os_err, rx_ready);
    else passes++;
    for (int n = 0; n < 2; n++) begin
      drive(8'h4A, 1'b0, 1'b0);
      checks++;
      if (os_valid !== 1'b0)
        $display("FAIL reset_mid_d%0d: got v=%0b t=%0d, want v=0", n, os_valid, os_type);
      else passes++;
      $display("reset_mid: sym=4a v=%0b", os_valid);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    drive(8'hF7, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) gap();
    checks++;
    if (os_valid !== 1'b0) $display("FAIL gap_quiet: got v=%0b, want v=0", os_valid);
    else passes++;
    drive(8'hF7, 1'b1, 1'b0);
    checks++;
    if (os_valid !== 1'b1 || os_type !== CC || os_err !== 1'b0)
      $display("FAIL cc_gap: got v=%0b t=%0d e=%0b, want v=1 t=%0d e=0", os_valid, os_type, os_err, CC);
    else passes++;
    $display("cc: v=%0b t=%0d", os_valid, os_type);
    drive(8'hDC, 1'b1, 1'b0);
    drive(8'h9C, 1'b1, 1'b0);
    checks++;
    if (os_valid !== 1'b1 || os_type !== SUF)
      $display("FAIL suf: got v=%0b t=%0d, want v=1 t=%0d", os_valid, os_type, SUF);
    else passes++;
    $display("suf: v=%0b t=%0d", os_valid, os_type);
    drive(8'hDC, 1'b1, 1'b0);
    drive(8'hDC, 1'b1, 1'b0);
    checks++;
    if (os_valid !== 1'b1 || os_type !== SNF)
      $display("FAIL snf: got v=%0b t=%0d, want v=1 t=%0d", os_valid, os_type, SNF);
    else passes++;
    $display("snf: v=%0b t=%0d", os_valid, os_type);
  endtask

  task automatic test_other_sets();
    do_reset();
    drive(8'hBC, 1'b1, 1'b0);
    drive(8'hB5, 1'b0, 1'b0);
    drive(8'h4C, 1'b0, 1'b0);
    drive(8'h4C, 1'b0, 1'b0);
    checks++;
    if (os_valid !== 1'b1 || os_type !== SPA)
      $display("FAIL spa: got v=%0b t=%0d, want v=1 t=%0d", os_valid, os_type, SPA);
    else passes++;
    $display("spa: v=%0b t=%0d", os_valid, os_type);
    drive(8'hBC, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) drive(8'h3C, 1'b1, 1'b0);
    checks++;
    if (os_valid !== 1'b1 || os_type !== VER)
      $display("FAIL ver: got v=%0b t=%0d, want v=1 t=%0d", os_valid, os_type, VER);
    else passes++;
    $display("ver: v=%0b t=%0d", os_valid, os_type);
    drive(8'hFD, 1'b1, 1'b0);
    drive(8'hFE, 1'b1, 1'b0);
    checks++;
    if (os_valid !== 1'b1 || os_type !== ECP)
      $display("FAIL ecp: got v=%0b t=%0d, want v=1 t=%0d", os_valid, os_type, ECP);
    else passes++;
    $display("ecp: v=%0b t=%0d", os_valid, os_type);
    drive(8'h9C, 1'b1, 1'b0);
    checks++;
    if (os_valid !== 1'b1 || os_type !== P || os_err !== 1'b0)
      $display("FAIL p_sym: got v=%0b t=%0d e=%0b, want v=1 t=%0d e=0", os_valid, os_type, os_err, P);
    else passes++;
    $display("p: v=%0b t=%0d", os_valid, os_type);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rx_is_k  = 1'b0;
    rx_err   = 1'b0;
    test_reset();
    test_sp();
    test_lookahead();
    test_idle_run();
    test_malformed();
    test_abort();
    test_reset_mid();
    test_gaps();
    test_other_sets();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
